mux4_1: RTL and testbench
=========================

// Module: mux4_1
// PURPOSE
// - 4-to-1 selector, WIDTH bits per input. Combinational output plus a registered copy.
// - Combinational out = input chosen by 2-bit select s; used directly in datapath steering.
// - out_q/valid_q give a one-cycle-registered version for timing-critical consumers.
// - One clock domain (clk); asynchronous active-high reset (rst).
// PARAMETERS
// - WIDTH      default 1        data width of a, b, c, d, out, out_q
// - RST_VAL    default 0        value loaded into out_q on reset (WIDTH bits)
// PORTS
// - clk      in   1      clock; all registers update on rising edge
// - rst      in   1      asynchronous reset, active-high
// - a        in   WIDTH  data input 0, selected when s=2'b00
// - b        in   WIDTH  data input 1, selected when s=2'b01
// - c        in   WIDTH  data input 2, selected when s=2'b10
// - d        in   WIDTH  data input 3, selected when s=2'b11
// - s        in   2      select
// - en       in   1      load enable for registered path
// - out      out  WIDTH  combinational selected data
// - out_q    out  WIDTH  registered selected data
// - valid_q  out  1      out_q holds data loaded since last reset
// - s_chg_q  out  1      one-cycle pulse: registered select differs from previous load
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high (clk, rst).
// - out: purely combinational, zero-latency function of (a,b,c,d,s), independent of clk/rst/en.
//   s=00->a, 01->b, 10->c, 11->d. s with X/Z bits: out=0 (synthesis default branch).
// - Reset (rst=1, asserted at any time, also mid-operation): out_q=RST_VAL, valid_q=0,
//   s_chg_q=0, internal last-select register=2'b00, immediately without waiting for clk.
//   out is unaffected by rst.
// - Rising clk, rst=0, en=1: out_q<=out; valid_q<=1; last_s<=s;
//   s_chg_q<=valid_q && (s!=last_s). Latency out->out_q = 1 cycle.
// - Rising clk, rst=0, en=0: out_q, valid_q, last_s hold; s_chg_q<=0.
// - First load after reset never raises s_chg_q (valid_q was 0).
// - Inputs changing in the same cycle as s: out_q captures the input selected by the new s.
// - rst deassertion is synchronised externally; the block imposes no recovery beyond
//   one clean clk edge before the first load.
// - All WIDTH bits select in parallel; no arithmetic, no width extension.
// TESTING
// - a=1,b=0,c=0,d=0,s=00 -> out=1; after 20 ns change only a=0,b=c=d=1,s=00 -> out=0.
// - a=1,b=0,c=1,d=1,s=01 -> out=0; a=1,b=1,c=0,d=1,s=10 -> out=0; a=b=c=1,d=0,s=11 -> out=0.
// - Walking-one per input for each s: out=1 only when the selected input is 1 (all 16 cases).
// - en=1, s=10, c=1, one clk edge -> out_q=1, valid_q=1, s_chg_q=0; next edge s=11,d=0 ->
//   out_q=0, s_chg_q=1; en=0 following edge -> out_q holds 0, s_chg_q=0.
// - Assert rst between clk edges with out_q=1 -> out_q=RST_VAL, valid_q=0 at once;
//   out still tracks s while rst=1.
// - WIDTH=8: a=8'hA5,b=8'h5A,c=8'hFF,d=8'h00, sweep s 00..11 -> out=A5,5A,FF,00.

Source files
------------

// File: rtl/mux4_1.sv
// 4-to-1 selector, WIDTH bits per input: combinational output plus a registered
// copy with a load-valid flag and a select-change pulse.

module mux4_1_lane (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] s,
    output logic       y
);
    // Unknown select falls to the default branch and drives 0.
    always_comb begin
        y = 1'b0;
        case (s)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            2'b11:   y = d;
            default: y = 1'b0;
        endcase
    end
endmodule

module mux4_1 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             valid_q,
    output logic             s_chg_q
);
    logic [1:0] last_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux4_1_lane u_lane (
            .a (a[i]),
            .b (b[i]),
            .c (c[i]),
            .d (d[i]),
            .s (s),
            .y (out[i])
        );
    end

    // The change pulse is gated by valid_q so the first load after reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= RST_VAL;
            valid_q <= 1'b0;
            s_chg_q <= 1'b0;
            last_s  <= 2'b00;
        end else if (en) begin
            out_q   <= out;
            valid_q <= 1'b1;
            last_s  <= s;
            s_chg_q <= valid_q && (s != last_s);
        end else begin
            s_chg_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux4_1.sv
// Scoreboard bench for mux4_1 (WIDTH=8): stimulus pushes expected samples,
// a monitor pops one per clock edge or reset assertion and compares.

module tb_mux4_1;
    localparam logic [7:0] RV = 8'h3C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b, c, d;
    logic [1:0] s;
    logic       en;
    logic [7:0] out, out_q;
    logic       valid_q, s_chg_q;

    mux4_1 #(.WIDTH(8), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .s(s), .en(en),
        .out(out), .out_q(out_q), .valid_q(valid_q), .s_chg_q(s_chg_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic [7:0] q;
        logic       v;
        logic       ch;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference state: what the registered outputs should show after the next event.
    logic [7:0] m_q;
    logic       m_v, m_c;
    logic [1:0] m_last;

    function automatic logic [7:0] pick(input logic [7:0] ia, ib, ic, id, input logic [1:0] is);
        logic [7:0] t[4];
        t[0] = ia; t[1] = ib; t[2] = ic; t[3] = id;
        return t[is];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.o  = pick(a, b, c, d, s);
        e.q  = m_q;
        e.v  = m_v;
        e.ch = m_c;
        sb.push_back(e);
    endtask

    // Drives one cycle at the falling edge; a rising rst here is also a sample event.
    task automatic cycle(input logic [7:0] ia, ib, ic, id, input logic [1:0] is,
                         input logic ie, input logic ir);
        @(negedge clk);
        a = ia; b = ib; c = ic; d = id; s = is; en = ie;
        if (ir) begin
            m_q = RV; m_v = 1'b0; m_c = 1'b0; m_last = 2'b00;
        end
        if (ir && !rst) push_exp();
        rst = ir;
        if (!ir) begin
            if (ie) begin
                m_c    = m_v && (is != m_last);
                m_q    = pick(ia, ib, ic, id, is);
                m_v    = 1'b1;
                m_last = is;
            end else begin
                m_c = 1'b0;
            end
        end
        push_exp();
    endtask

    // Monitor
    always begin
        exp_t e;
        @(posedge clk or posedge rst);
        #1;
        if (!done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
            end else begin
                e = sb.pop_front();
                chk("out",     out,            e.o);
                chk("out_q",   out_q,          e.q);
                chk("valid_q", {7'd0, valid_q}, {7'd0, e.v});
                chk("s_chg_q", {7'd0, s_chg_q}, {7'd0, e.ch});
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; s = 2'b00;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
        m_q = RV; m_v = 1'b0; m_c = 1'b0; m_last = 2'b00;
        #1;
        push_exp();          // reset assertion sample
        rst = 1'b1;
        push_exp();          // first clock edge with rst held
        cycle(8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
        cycle(8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);

        // Combinational selection, directed
        cycle(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        cycle(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        cycle(8'h00, 8'h01, 8'h01, 8'h01, 2'b00, 1'b0, 1'b0);
        cycle(8'h01, 8'h00, 8'h01, 8'h01, 2'b01, 1'b0, 1'b0);
        cycle(8'h01, 8'h01, 8'h00, 8'h01, 2'b10, 1'b0, 1'b0);
        cycle(8'h01, 8'h01, 8'h01, 8'h00, 2'b11, 1'b0, 1'b0);

        // Walking one across inputs for each select
        for (int si = 0; si < 4; si++)
            for (int k = 0; k < 4; k++)
                cycle((k == 0) ? 8'h01 : 8'h00, (k == 1) ? 8'h01 : 8'h00,
                      (k == 2) ? 8'h01 : 8'h00, (k == 3) ? 8'h01 : 8'h00,
                      2'(si), 1'b0, 1'b0);

        // Registered path: first load, select change, hold
        cycle(8'h00, 8'h00, 8'h01, 8'h00, 2'b10, 1'b1, 1'b0);
        cycle(8'h00, 8'h00, 8'h01, 8'h00, 2'b11, 1'b1, 1'b0);
        cycle(8'h01, 8'h01, 8'h01, 8'h01, 2'b01, 1'b0, 1'b0);
        cycle(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);

        // Mid-cycle reset with out_q loaded; out keeps tracking s under reset
        cycle(8'h01, 8'h00, 8'h01, 8'h00, 2'b10, 1'b1, 1'b1);
        cycle(8'h01, 8'h00, 8'h01, 8'h00, 2'b01, 1'b1, 1'b1);
        cycle(8'h01, 8'h00, 8'h01, 8'h00, 2'b00, 1'b0, 1'b0);
        cycle(8'h01, 8'h00, 8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
        cycle(8'h01, 8'h00, 8'h01, 8'h00, 2'b10, 1'b1, 1'b0);

        // Full-width sweep
        for (int si = 0; si < 4; si++)
            cycle(8'hA5, 8'h5A, 8'hFF, 8'h00, 2'(si), 1'b1, 1'b0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++)
            cycle(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  2'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));

        @(posedge clk);
        #2;
        done = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
